// File: rtl/mem_req_ctrl.sv
// Request/response initiator for the single-port synchronous memory: single and burst reads/writes.
// Optional start-address bounds check is enabled by defining MEM_BOUNDS_CHK_EN.
//
// state | meaning
// IDLE  | waiting for a request; no memory access
// WRITE | one memory write per write-data handshake
// READ  | one memory read issued per cycle

module mem_req_ctrl #(
  parameter int MEM_SIZE = 256,
  parameter int LEN_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [31:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_data_in,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic             rsp_last,
  output logic             busy,
  output logic             err,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wr_data,
  output logic             mem_we,
  output logic             mem_re,
  input  logic [31:0]      mem_rd_data
);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  localparam logic [31:0] LAST_ADDR = 32'(MEM_SIZE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [31:0]        cur_addr;
  logic [31:0]        addr_nxt;
  logic [LEN_W-1:0]   beat_cnt;
  logic               accept;
  logic               start;
  logic               wr_hs;
  logic               last_beat;
  logic               req_oob;

`ifdef MEM_BOUNDS_CHK_EN
  logic err_q;

  assign req_oob = (req_addr >= 32'(MEM_SIZE));

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= accept && req_oob;
  end

  assign err = err_q;
`else
  assign req_oob = 1'b0;
  assign err     = 1'b0;
`endif

  assign accept    = req_valid && req_ready;
  assign start     = accept && !req_oob;
  assign wr_hs     = wr_valid && wr_ready;
  assign last_beat = (beat_cnt == '0);
  // Wrap only at the top word; an out-of-range address just keeps incrementing.
  assign addr_nxt  = (cur_addr == LAST_ADDR) ? 32'd0 : cur_addr + 32'd1;
  assign busy      = (state != IDLE);
  assign mem_addr  = cur_addr;
  assign rsp_data  = mem_rd_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = req_we ? WRITE : READ;
      WRITE:   if (wr_hs && last_beat) state_nxt = IDLE;
      READ:    if (last_beat) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    wr_ready    = 1'b0;
    mem_we      = 1'b0;
    mem_re      = 1'b0;
    mem_wr_data = 32'd0;
    case (state)
      IDLE:  req_ready = !rst;
      WRITE: begin
        wr_ready    = !rst;
        mem_we      = wr_valid && !rst;
        mem_wr_data = wr_data_in;
      end
      READ:  mem_re = !rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_addr <= 32'd0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cur_addr <= req_addr;
          beat_cnt <= req_len;
        end
        WRITE: if (wr_hs) begin
          cur_addr <= addr_nxt;
          if (!last_beat) beat_cnt <= beat_cnt - LEN_W'(1);
        end
        READ: begin
          cur_addr <= addr_nxt;
          if (!last_beat) beat_cnt <= beat_cnt - LEN_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Response pipeline is decoupled from the FSM so the next request can overlap it.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_last  <= 1'b0;
    end else begin
      rsp_valid <= mem_re;
      rsp_last  <= mem_re && last_beat;
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Directed bench for mem_req_ctrl with a behavioural registered-read memory attached.
// Covers both builds of MEM_BOUNDS_CHK_EN.

module tb_mem_req_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [3:0]  req_len;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data_in;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_last;
  logic        busy;
  logic        err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic        mem_we;
  logic        mem_re;
  logic [31:0] mem_rd_data;

  logic        mem_init;
  logic [31:0] mem_model [256];
  logic [31:0] exp_d [16];
  int          checks;
  int          errors;

  mem_req_ctrl #(.MEM_SIZE(256), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_len(req_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data_in(wr_data_in),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .busy(busy), .err(err),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rd_data(mem_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pat(input logic [31:0] a);
    return 32'hA5A5_0000 + {24'd0, a[7:0]};
  endfunction

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem_model[i] <= pat(32'(i));
    end else begin
      if (mem_we) mem_model[mem_addr[7:0]] <= mem_wr_data;
      if (mem_re) mem_rd_data <= mem_model[mem_addr[7:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Entered just after a falling edge; leaves in the cycle carrying the last response.
  task automatic read_burst(input logic [31:0] a, input int n);
    logic [31:0] ea;
    ea        = a;
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = a;
    req_len   = 4'(n - 1);
    #1 chk("rd_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      #1;
      chk("rd_mem_re", mem_re, 1);
      chk("rd_mem_addr", mem_addr, ea);
      chk("rd_no_we", mem_we, 0);
      if (k > 0) begin
        chk("rd_rsp_valid", rsp_valid, 1);
        chk("rd_rsp_data", rsp_data, exp_d[k-1]);
        chk("rd_rsp_last_mid", rsp_last, 0);
      end
      ea = (ea == 32'd255) ? 32'd0 : ea + 32'd1;
      @(negedge clk);
    end
    #1;
    chk("rd_rsp_valid_end", rsp_valid, 1);
    chk("rd_rsp_data_end", rsp_data, exp_d[n-1]);
    chk("rd_rsp_last_end", rsp_last, 1);
    chk("rd_mem_re_off", mem_re, 0);
    chk("rd_busy_off", busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] gap_pat;
    int         beat;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    mem_init   = 1'b1;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_addr   = 32'd0;
    req_len    = 4'd0;
    wr_valid   = 1'b0;
    wr_data_in = 32'd0;
    gap_pat    = 6'b101101;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_last", rsp_last, 0);
    chk("rst_err", err, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_re", mem_re, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst      = 1'b0;
    mem_init = 1'b0;
    #1 chk("idle_req_ready", req_ready, 1);

    // single write then single read
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd5; req_len = 4'd0;
    #1 chk("sw_no_we_accept", mem_we, 0);
    @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b1; wr_data_in = 32'hDEAD_BEEF;
    #1;
    chk("sw_busy", busy, 1);
    chk("sw_wr_ready", wr_ready, 1);
    chk("sw_mem_we", mem_we, 1);
    chk("sw_mem_addr", mem_addr, 5);
    chk("sw_mem_wr_data", mem_wr_data, 32'hDEAD_BEEF);
    @(negedge clk);
    wr_valid = 1'b0;
    #1;
    chk("sw_idle", busy, 0);
    chk("sw_we_once", mem_we, 0);
    chk("sw_wdata_zero", mem_wr_data, 0);
    exp_d[0] = 32'hDEAD_BEEF;
    read_burst(32'd5, 1);

    // burst write with gaps, then read it back
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h10; req_len = 4'd3;
    #1 chk("bw_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
    beat = 0;
    for (int i = 0; i < 6; i++) begin
      wr_valid   = gap_pat[i];
      wr_data_in = 32'h1111_0000 + 32'(beat);
      #1;
      chk("bw_busy", busy, 1);
      chk("bw_mem_we", mem_we, 32'(gap_pat[i]));
      chk("bw_no_re", mem_re, 0);
      if (gap_pat[i]) begin
        chk("bw_mem_addr", mem_addr, 32'h10 + 32'(beat));
        chk("bw_mem_wr_data", mem_wr_data, 32'h1111_0000 + 32'(beat));
        beat++;
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    #1;
    chk("bw_done_idle", busy, 0);
    chk("bw_done_no_we", mem_we, 0);
    for (int k = 0; k < 4; k++) exp_d[k] = 32'h1111_0000 + 32'(k);
    read_burst(32'h10, 4);

    // address wrap at the top of memory
    @(negedge clk);
    exp_d[0] = pat(32'd254);
    exp_d[1] = pat(32'd255);
    exp_d[2] = pat(32'd0);
    exp_d[3] = pat(32'd1);
    read_burst(32'd254, 4);

    // reset in the middle of a write burst
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_len = 4'd7;
    @(negedge clk);
    req_valid = 1'b0;
    for (int b = 0; b < 2; b++) begin
      wr_valid   = 1'b1;
      wr_data_in = 32'h2222_0000 + 32'(b);
      #1;
      chk("rb_mem_we", mem_we, 1);
      chk("rb_mem_addr", mem_addr, 32'h20 + 32'(b));
      @(negedge clk);
    end
    rst        = 1'b1;
    wr_data_in = 32'h2222_0002;
    #1;
    chk("rb_rst_no_we", mem_we, 0);
    chk("rb_rst_wr_ready", wr_ready, 0);
    chk("rb_rst_req_ready", req_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rb_busy", busy, 0);
    chk("rb_no_we", mem_we, 0);
    chk("rb_req_ready", req_ready, 1);
    chk("rb_rsp_valid", rsp_valid, 0);
    wr_valid = 1'b0;
    @(negedge clk);
    exp_d[0] = 32'h2222_0000;
    exp_d[1] = 32'h2222_0001;
    exp_d[2] = pat(32'h22);
    read_burst(32'h20, 3);

    // back-to-back read then write
    @(negedge clk);
    exp_d[0] = pat(32'd3);
    read_burst(32'd3, 1);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd4; req_len = 4'd0;
    #1;
    chk("b2b_req_ready", req_ready, 1);
    chk("b2b_rsp_overlap", rsp_valid, 1);
    @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b1; wr_data_in = 32'h4444_4444;
    #1;
    chk("b2b_mem_we", mem_we, 1);
    chk("b2b_no_re", mem_re, 0);
    chk("b2b_mem_addr", mem_addr, 4);
    chk("b2b_rsp_clear", rsp_valid, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    exp_d[0] = 32'h4444_4444;
    read_burst(32'd4, 1);

    // out-of-range start address
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd300; req_len = 4'd0;
    #1 chk("oob_req_ready", req_ready, 1);
    @(negedge clk);
    req_valid = 1'b0;
`ifdef MEM_BOUNDS_CHK_EN
    #1;
    chk("oob_rd_err", err, 1);
    chk("oob_rd_busy", busy, 0);
    chk("oob_rd_no_re", mem_re, 0);
    chk("oob_rd_no_we", mem_we, 0);
    @(negedge clk);
    #1 chk("oob_rd_err_pulse", err, 0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd300; req_len = 4'd0;
    @(negedge clk);
    req_valid = 1'b0; wr_valid = 1'b1; wr_data_in = 32'h5555_5555;
    #1;
    chk("oob_wr_err", err, 1);
    chk("oob_wr_ready", wr_ready, 0);
    chk("oob_wr_no_we", mem_we, 0);
    chk("oob_wr_busy", busy, 0);
    @(negedge clk);
    wr_valid = 1'b0;
    #1 chk("oob_wr_err_pulse", err, 0);
`else
    #1;
    chk("oob_busy", busy, 1);
    chk("oob_mem_re", mem_re, 1);
    chk("oob_mem_addr", mem_addr, 300);
    chk("oob_err", err, 0);
    @(negedge clk);
    #1;
    chk("oob_err_after", err, 0);
    chk("oob_rsp_valid", rsp_valid, 1);
    chk("oob_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
- Initiator for the team's synchronous single-port memory: converts a request/response interface into memory-port cycles (addr, wr_data, we, re) and collects read data.
- Supports single and burst (1–16 word) reads and writes with sequential word addressing.
- Write data is taken from a valid/ready stream.
- Sits between a requester (CPU load/store unit or DMA) and the memory instance.

Parameters:
- MEM_SIZE, 256, number of 32-bit words in the attached memory; used for address wrap and the bounds check.
- LEN_W, 4, width of the burst-length field; a burst is req_len+1 beats (max 2^LEN_W).

Ports:
- clk  in  1  rising-edge clock, shared with the memory
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write burst, 0 = read burst
- req_addr  in  32  start word address
- req_len  in  LEN_W  beats minus one
- wr_valid  in  1  write-data beat present
- wr_ready  out  1  controller accepts a write beat
- wr_data_in  in  32  write-data beat
- rsp_valid  out  1  read-data beat valid (no backpressure)
- rsp_data  out  32  read-data beat
- rsp_last  out  1  final beat of the read burst
- busy  out  1  burst in progress (state != IDLE)
- err  out  1  one-cycle bounds-error pulse; tied 0 unless the feature is enabled
- mem_addr  out  32  memory word address
- mem_wr_data  out  32  memory write data
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_rd_data  in  32  memory read data, registered in memory, valid 1 cycle after mem_re

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values:
  - State goes to IDLE. cur_addr=0, beat_cnt=0, rsp_valid=0, rsp_last=0, err=0.
  - While rst=1: req_ready=0, wr_ready=0, mem_we=0, mem_re=0.
  - rst mid-burst: the burst is abandoned. No further mem_we/mem_re from the next edge. Any in-flight read response is dropped (rsp_valid=0 after the edge).
- FSM states: IDLE, WRITE, READ.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready: latch cur_addr=req_addr, beat_cnt=req_len, dir=req_we.
  - Next state is WRITE if req_we=1, else READ.
  - No memory access is issued in the acceptance cycle.
- WRITE:
  - wr_ready=1.
  - mem_we = wr_valid (combinational), mem_addr=cur_addr, mem_wr_data=wr_data_in.
  - Each handshake (wr_valid && wr_ready) advances cur_addr. If beat_cnt==0, go to IDLE; else decrement beat_cnt.
  - If wr_valid=0 the state holds, mem_we=0, and the address is unchanged.
- READ:
  - mem_re=1 every cycle, mem_addr=cur_addr.
  - Each cycle advances cur_addr. If beat_cnt==0, go to IDLE; else decrement beat_cnt.
  - Issue rate is one beat per cycle; a (len+1)-beat read spends len+1 cycles in READ.
- Response path:
  - rsp_valid is mem_re registered.
  - rsp_last is (mem_re && beat_cnt==0) registered.
  - rsp_data = mem_rd_data, combinational pass-through.
  - Latency: mem_re at cycle N gives rsp_valid at N+1.
  - The response pipeline runs independently of the FSM. A new request may be accepted in the cycle after the last read issue, while its response is still emerging.
- Address advance: word addressing, +1 per beat. If cur_addr == MEM_SIZE-1, the next address is 0 (wrap).
- busy = (state != IDLE).
- mem_we and mem_re are never both 1.
- Outside WRITE/READ: mem_we=0, mem_re=0, mem_wr_data=0, mem_addr=cur_addr.

Optional Feature:
- Macro: MEM_BOUNDS_CHK_EN.
- When defined:
  - A request accepted with req_addr >= MEM_SIZE stays in IDLE and issues no memory access.
  - err is 1 in the cycle after acceptance, for exactly one cycle.
  - For a rejected write request, the requester must not send write beats (wr_ready stays 0).
- When undefined:
  - err is constant 0 and no check is made.
  - An out-of-range start address is driven to mem_addr unchanged; wrap applies only at MEM_SIZE-1.

Test Plan:
- Single write then single read: write addr 5, data 0xDEADBEEF, len 0; then read addr 5, len 0 -> mem_we high one cycle at addr 5. rsp_valid=1 one cycle after mem_re, with rsp_data=0xDEADBEEF and rsp_last=1.
- Burst write with gaps: addr 0x10, len 3, wr_valid toggling 1,0,1,1,0,1 -> mem_we only on handshake cycles, at addrs 0x10,0x11,0x12,0x13; return to IDLE after the 4th beat. Then read burst 0x10 len 3 -> 4 consecutive rsp beats matching the written data, rsp_last on the 4th only.
- Wrap: read len 3 at addr 254 (MEM_SIZE=256) -> mem_addr sequence 254, 255, 0, 1.
- Reset mid-burst: write len 7, assert rst after 2 beats -> no mem_we after the reset edge, busy=0. req_ready=1 the cycle after rst deasserts. A new read returns correct data.
- Back-to-back: read len 0 at addr 3, immediately followed by write len 0 at addr 4 -> the read's rsp_valid coincides with the write request acceptance. Both complete correctly and mem_we/mem_re are never simultaneously 1.
- Bounds: request addr 300 with MEM_BOUNDS_CHK_EN -> err=1 for one cycle, no mem_we/mem_re, busy stays 0. Without the macro -> mem_re issued with mem_addr=300 and err=0.
